// File: rtl/memory_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : memory_bridge_pkg
// Description : Shared types and constants for the load/store memory bridge.
// Revision    : 1.0 - initial release
// ============================================================================
package memory_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT1 = 2'd1,
        ST_BEAT2 = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [2:0] c_sec_load = 3'b000;
    localparam logic [2:0] c_sec_sb   = 3'b001;
    localparam logic [2:0] c_sec_sh   = 3'b011;
    localparam logic [2:0] c_sec_sw   = 3'b111;

    localparam logic [3:0] c_mask_byte = 4'b0001;
    localparam logic [3:0] c_mask_half = 4'b0011;
    localparam logic [3:0] c_mask_word = 4'b1111;

    // Unknown section codes fall back to a full word, as does a load.
    function automatic logic [3:0] section_mask(input logic [2:0] sections);
        case (sections)
            c_sec_sb:             return c_mask_byte;
            c_sec_sh:             return c_mask_half;
            c_sec_sw, c_sec_load: return c_mask_word;
            default:              return c_mask_word;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/memory_bridge_if.sv
`default_nettype none
// ============================================================================
// Module      : memory_bridge_if
// Description : Word-wide ready/valid memory bus between bridge and memory.
// Revision    : 1.0 - initial release
// ============================================================================
interface memory_bridge_if;
    logic        bus_valid;
    logic        bus_write;
    logic [31:0] bus_address;
    logic [3:0]  bus_byte_enable;
    logic [31:0] bus_write_data;
    logic        bus_ready;
    logic [31:0] bus_read_data;

    modport master (
        output bus_valid, bus_write, bus_address, bus_byte_enable, bus_write_data,
        input  bus_ready, bus_read_data
    );

    modport slave (
        input  bus_valid, bus_write, bus_address, bus_byte_enable, bus_write_data,
        output bus_ready, bus_read_data
    );
endinterface
`default_nettype wire

// File: rtl/memory_bridge_lane_shifter.sv
`default_nettype none
// ============================================================================
// Module      : lane_shifter
// Description : Byte-lane placement for stores and lane extraction for loads.
// Revision    : 1.0 - initial release
// ============================================================================
module lane_shifter (
    input  logic [1:0]  i_offset,
    input  logic [3:0]  i_mask,
    input  logic [31:0] i_store_data,
    input  logic [63:0] i_load_data,
    output logic [7:0]  o_mask8,
    output logic [63:0] o_data64,
    output logic [31:0] o_load_word
);
    logic [5:0] w_bit_shift;

    assign w_bit_shift = {1'b0, i_offset, 3'b000};
    assign o_mask8     = {4'b0000, i_mask} << i_offset;
    assign o_data64    = {32'h0, i_store_data} << w_bit_shift;
    assign o_load_word = 32'(i_load_data >> w_bit_shift);
endmodule
`default_nettype wire

// File: rtl/memory_bridge.sv
`default_nettype none
// ============================================================================
// Module      : memory_bridge
// Description : Core load/store port to word-wide ready/valid bus, with lane
//               steering, boundary splitting, stall and per-beat timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module memory_bridge
    import memory_bridge_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            access_enable,
    input  logic [31:0]     memory_address,
    input  logic [2:0]      memory_write_sections,
    input  logic [31:0]     store_value,
    output logic [31:0]     load_value,
    output logic            stall,
    output logic            bus_error,
    memory_bridge_if.master bus
);
    localparam logic [15:0] c_timeout = 16'(TIMEOUT_CYCLES);

    state_t      r_state, w_next_state;
    logic        r_write;
    logic [1:0]  r_offset;
    logic [3:0]  r_mask;
    logic [31:0] r_store;
    logic [29:0] r_word_addr;
    logic [31:0] r_w1;
    logic [15:0] r_wait;
    logic        r_timeout;
    logic [31:0] r_load_value;

    logic [7:0]  w_mask8;
    logic [63:0] w_data64, w_load64;
    logic [31:0] w_load_word;
    logic        w_in_beat, w_need_beat2, w_wait_expired;
    logic        w_latch, w_clear_wait, w_timeout_hit, w_capture_w1, w_last_beat_done;

    lane_shifter u_lane_shifter (
        .i_offset     (r_offset),
        .i_mask       (r_mask),
        .i_store_data (r_store),
        .i_load_data  (w_load64),
        .o_mask8      (w_mask8),
        .o_data64     (w_data64),
        .o_load_word  (w_load_word)
    );

    assign w_in_beat      = (r_state == ST_BEAT1) || (r_state == ST_BEAT2);
    assign w_need_beat2   = |w_mask8[7:4];
    assign w_wait_expired = (r_wait + 16'd1) == c_timeout;
    // In beat 1 the high word is zero; in beat 2 the first word was captured earlier.
    assign w_load64       = (r_state == ST_BEAT2) ? {bus.bus_read_data, r_w1}
                                                  : {32'h0, bus.bus_read_data};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_next_state;
    end

    always_comb begin
        w_next_state     = r_state;
        w_latch          = 1'b0;
        w_clear_wait     = 1'b0;
        w_timeout_hit    = 1'b0;
        w_capture_w1     = 1'b0;
        w_last_beat_done = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (access_enable) begin
                    w_next_state = ST_BEAT1;
                    w_latch      = 1'b1;
                    w_clear_wait = 1'b1;
                end
            end
            ST_BEAT1: begin
                if (bus.bus_ready) begin
                    w_capture_w1 = 1'b1;
                    if (w_need_beat2) begin
                        w_next_state = ST_BEAT2;
                        w_clear_wait = 1'b1;
                    end else begin
                        w_next_state     = ST_DONE;
                        w_last_beat_done = 1'b1;
                    end
                end else if (w_wait_expired) begin
                    w_next_state  = ST_DONE;
                    w_timeout_hit = 1'b1;
                end
            end
            ST_BEAT2: begin
                if (bus.bus_ready) begin
                    w_next_state     = ST_DONE;
                    w_last_beat_done = 1'b1;
                end else if (w_wait_expired) begin
                    w_next_state  = ST_DONE;
                    w_timeout_hit = 1'b1;
                end
            end
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_write      <= 1'b0;
            r_offset     <= 2'b00;
            r_mask       <= 4'b0000;
            r_store      <= 32'h0;
            r_word_addr  <= 30'h0;
            r_w1         <= 32'h0;
            r_wait       <= 16'h0;
            r_timeout    <= 1'b0;
            r_load_value <= 32'h0;
        end else begin
            r_timeout <= w_timeout_hit;
            if (w_latch) begin
                r_write     <= (memory_write_sections != c_sec_load);
                r_offset    <= memory_address[1:0];
                r_mask      <= section_mask(memory_write_sections);
                r_store     <= store_value;
                r_word_addr <= memory_address[31:2];
            end
            if (w_clear_wait)
                r_wait <= 16'h0;
            else if (w_in_beat && !bus.bus_ready)
                r_wait <= r_wait + 16'd1;
            if (w_capture_w1)
                r_w1 <= bus.bus_read_data;
            if (!r_write) begin
                if (w_last_beat_done)
                    r_load_value <= w_load_word;
                else if (w_timeout_hit)
                    r_load_value <= 32'h0;
            end
        end
    end

    // Bus fields are driven only during a beat so they read as zero when idle.
    always_comb begin
        bus.bus_valid       = w_in_beat;
        bus.bus_write       = w_in_beat && r_write;
        bus.bus_address     = 32'h0;
        bus.bus_byte_enable = 4'b0000;
        bus.bus_write_data  = 32'h0;
        if (r_state == ST_BEAT1) begin
            bus.bus_address     = {r_word_addr, 2'b00};
            bus.bus_byte_enable = r_write ? w_mask8[3:0] : 4'b1111;
            bus.bus_write_data  = r_write ? w_data64[31:0] : 32'h0;
        end else if (r_state == ST_BEAT2) begin
            bus.bus_address     = {r_word_addr + 30'd1, 2'b00};
            bus.bus_byte_enable = r_write ? w_mask8[7:4] : 4'b1111;
            bus.bus_write_data  = r_write ? w_data64[63:32] : 32'h0;
        end
    end

    assign stall      = access_enable && (r_state != ST_DONE);
    assign bus_error  = r_timeout;
    assign load_value = r_load_value;

endmodule
`default_nettype wire

// File: tb/tb_memory_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_memory_bridge
// Description : Self-checking bench: directed vector table, timeout and reset
//               sequences, and randomized accesses against a byte-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_bridge;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        wr;
        logic [31:0] data;
    } beat_t;

    typedef struct {
        logic [31:0] addr;
        logic [2:0]  sec;
        logic [31:0] val;
        int          nb;
        logic [31:0] a1;
        logic [3:0]  be1;
        logic [31:0] d1;
        logic [31:0] a2;
        logic [3:0]  be2;
        logic [31:0] d2;
        int          stall_n;
        logic [31:0] load;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        access_enable;
    logic [31:0] memory_address;
    logic [2:0]  memory_write_sections;
    logic [31:0] store_value;
    logic [31:0] load_value;
    logic        stall;
    logic        bus_error;

    memory_bridge_if bus ();

    memory_bridge #(.TIMEOUT_CYCLES(4)) dut (
        .clk                   (clk),
        .reset_n               (reset_n),
        .access_enable         (access_enable),
        .memory_address        (memory_address),
        .memory_write_sections (memory_write_sections),
        .store_value           (store_value),
        .load_value            (load_value),
        .stall                 (stall),
        .bus_error             (bus_error),
        .bus                   (bus)
    );

    always #5 clk = ~clk;

    int    n_tests = 0;
    int    n_fail  = 0;
    int    ready_mode = 1;   // 0 never ready, 1 always ready, 2 random ready
    beat_t got_q[$];
    beat_t exp_q[$];

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        case (a)
            32'h0000_0400: return 32'h4433_2211;
            32'h0000_0404: return 32'h8877_6655;
            32'hFFFF_FFFC: return 32'hA1B2_C3D4;
            32'h0000_0000: return 32'h0F1E_2D3C;
            default:       return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Memory slave: drives ready/data at negedge and records completed beats.
    initial begin
        int  low;
        logic r;
        low = 0;
        bus.bus_ready     = 1'b0;
        bus.bus_read_data = 32'h0;
        forever begin
            @(negedge clk);
            if (ready_mode == 0)      r = 1'b0;
            else if (ready_mode == 1) r = 1'b1;
            else                      r = (low >= 2) ? 1'b1 : ($urandom_range(0, 2) != 0);
            bus.bus_ready     = r;
            bus.bus_read_data = r ? rd_word(bus.bus_address) : 32'hBAD0_BAD0;
            #1;
            if (bus.bus_valid && bus.bus_ready)
                got_q.push_back('{bus.bus_address, bus.bus_byte_enable, bus.bus_write, bus.bus_write_data});
            low = (bus.bus_valid && !r) ? low + 1 : 0;
        end
    end

    task automatic run_access(input logic [31:0] a, input logic [2:0] s, input logic [31:0] v,
                              input int mode, output int stall_n, output int valid_n,
                              output int err_n, output logic [31:0] lv);
        bit done;
        done = 1'b0;
        stall_n = 0; valid_n = 0; err_n = 0; lv = 32'h0;
        @(posedge clk); #1;
        got_q.delete();
        ready_mode            = mode;
        memory_address        = a;
        memory_write_sections = s;
        store_value           = v;
        access_enable         = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk); #2;
            if (bus.bus_valid) valid_n++;
            if (bus_error)     err_n++;
            if (!stall) begin
                lv   = load_value;
                done = 1'b1;
                break;
            end
            stall_n++;
        end
        if (!done) begin
            n_tests++; n_fail++;
            $display("FAIL access-complete: got stall stuck expected release within 200 cycles");
        end
        @(posedge clk); #1;
        access_enable = 1'b0;
        @(negedge clk); #2;
        if (bus_error) err_n++;
    endtask

    task automatic check_beats(input string tag);
        chk({tag, " beat count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            chk($sformatf("%s b%0d addr", tag, i), got_q[i].addr, exp_q[i].addr);
            chk($sformatf("%s b%0d be", tag, i), 32'(got_q[i].be), 32'(exp_q[i].be));
            chk($sformatf("%s b%0d write", tag, i), 32'(got_q[i].wr), 32'(exp_q[i].wr));
            if (exp_q[i].wr)
                chk($sformatf("%s b%0d data", tag, i), got_q[i].data, exp_q[i].data);
        end
    endtask

    // Byte-level reference: byte k of the access lives at address a+k; beats are
    // the distinct words touched, lane data is store byte (4*beat + lane - offset).
    task automatic build_model(input logic [31:0] a, input logic [2:0] s, input logic [31:0] v,
                               inout logic [31:0] cur_load);
        int          n, o, idx;
        logic [31:0] b, w, rw;
        logic [31:0] ld;
        bit          is_load;
        is_load = (s == 3'b000);
        n = (s == 3'b001) ? 1 : (s == 3'b011) ? 2 : 4;
        o = int'(a[1:0]);
        ld = 32'h0;
        exp_q.delete();
        for (int k = 0; k < n; k++) begin
            b = a + 32'(k);
            w = {b[31:2], 2'b00};
            if (exp_q.size() == 0 || exp_q[exp_q.size()-1].addr != w)
                exp_q.push_back('{w, 4'b0000, !is_load, 32'h0});
            idx = exp_q.size() - 1;
            exp_q[idx].be[b[1:0]] = 1'b1;
            rw = rd_word(w);
            ld[8*k +: 8] = rw[8*int'(b[1:0]) +: 8];
        end
        for (int j = 0; j < exp_q.size(); j++) begin
            for (int l = 0; l < 4; l++) begin
                int k;
                k = 4*j + l - o;
                if (k >= 0 && k < 4) exp_q[j].data[8*l +: 8] = v[8*k +: 8];
            end
            if (is_load) exp_q[j].be = 4'b1111;
        end
        if (is_load) cur_load = ld;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got simulation still running expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t        vecs[11];
        logic [2:0]  secs[7];
        int          sn, vn, en;
        logic [31:0] lv, cur_load;

        vecs[0]  = '{32'h100, 3'b111, 32'hDEADBEEF, 1, 32'h100, 4'hF, 32'hDEADBEEF, 32'h0, 4'h0, 32'h0, 2, 32'h0};
        vecs[1]  = '{32'h203, 3'b001, 32'h000000AB, 1, 32'h200, 4'h8, 32'hAB000000, 32'h0, 4'h0, 32'h0, 2, 32'h0};
        vecs[2]  = '{32'h307, 3'b011, 32'h00001234, 2, 32'h304, 4'h8, 32'h34000000, 32'h308, 4'h1, 32'h00000012, 3, 32'h0};
        vecs[3]  = '{32'h401, 3'b000, 32'h0, 2, 32'h400, 4'hF, 32'h0, 32'h404, 4'hF, 32'h0, 3, 32'h55443322};
        vecs[4]  = '{32'h001, 3'b111, 32'h11223344, 2, 32'h000, 4'hE, 32'h22334400, 32'h004, 4'h1, 32'h00000011, 3, 32'h55443322};
        vecs[5]  = '{32'h302, 3'b011, 32'hCAFE5678, 1, 32'h300, 4'hC, 32'h56780000, 32'h0, 4'h0, 32'h0, 2, 32'h55443322};
        vecs[6]  = '{32'h7FF, 3'b001, 32'h123456CD, 1, 32'h7FC, 4'h8, 32'hCD000000, 32'h0, 4'h0, 32'h0, 2, 32'h55443322};
        vecs[7]  = '{32'h600, 3'b101, 32'h11223344, 1, 32'h600, 4'hF, 32'h11223344, 32'h0, 4'h0, 32'h0, 2, 32'h55443322};
        vecs[8]  = '{32'hFFFFFFFE, 3'b000, 32'h0, 2, 32'hFFFFFFFC, 4'hF, 32'h0, 32'h0, 4'hF, 32'h0, 3, 32'h2D3CA1B2};
        vecs[9]  = '{32'h400, 3'b000, 32'h0, 1, 32'h400, 4'hF, 32'h0, 32'h0, 4'h0, 32'h0, 2, 32'h44332211};
        vecs[10] = '{32'h102, 3'b010, 32'hAABBCCDD, 2, 32'h100, 4'hC, 32'hCCDD0000, 32'h104, 4'h3, 32'h0000AABB, 3, 32'h44332211};
        secs = '{3'b000, 3'b001, 3'b011, 3'b111, 3'b000, 3'b010, 3'b101};

        reset_n = 1'b0; access_enable = 1'b0;
        memory_address = 32'h0; memory_write_sections = 3'b000; store_value = 32'h0;
        repeat (2) @(posedge clk); #1;
        chk("reset bus_valid", 32'(bus.bus_valid), 32'h0);
        chk("reset bus_write", 32'(bus.bus_write), 32'h0);
        chk("reset bus_error", 32'(bus_error), 32'h0);
        chk("reset bus_address", bus.bus_address, 32'h0);
        chk("reset byte_enable", 32'(bus.bus_byte_enable), 32'h0);
        chk("reset write_data", bus.bus_write_data, 32'h0);
        chk("reset load_value", load_value, 32'h0);
        chk("reset stall low", 32'(stall), 32'h0);
        access_enable = 1'b1; #1;
        chk("reset stall follows enable", 32'(stall), 32'h1);
        access_enable = 1'b0;
        @(negedge clk); reset_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            string tag;
            logic  wr;
            tag = $sformatf("vec%0d", i);
            wr  = (vecs[i].sec != 3'b000);
            exp_q.delete();
            exp_q.push_back('{vecs[i].a1, vecs[i].be1, wr, vecs[i].d1});
            if (vecs[i].nb == 2) exp_q.push_back('{vecs[i].a2, vecs[i].be2, wr, vecs[i].d2});
            run_access(vecs[i].addr, vecs[i].sec, vecs[i].val, 1, sn, vn, en, lv);
            check_beats(tag);
            chk({tag, " stall cycles"}, 32'(sn), 32'(vecs[i].stall_n));
            chk({tag, " valid cycles"}, 32'(vn), 32'(vecs[i].nb));
            chk({tag, " bus_error"}, 32'(en), 32'h0);
            chk({tag, " load_value"}, lv, vecs[i].load);
        end
        cur_load = 32'h44332211;

        // Timeout on a load that never gets bus_ready.
        run_access(32'h500, 3'b000, 32'h0, 0, sn, vn, en, lv);
        chk("timeout beats", 32'(got_q.size()), 32'h0);
        chk("timeout valid cycles", 32'(vn), 32'd4);
        chk("timeout stall cycles", 32'(sn), 32'd5);
        chk("timeout error pulse", 32'(en), 32'd1);
        chk("timeout load_value", lv, 32'h0);

        run_access(32'h404, 3'b000, 32'h0, 1, sn, vn, en, lv);
        chk("recover load_value", lv, 32'h88776655);
        chk("recover bus_error", 32'(en), 32'h0);

        // Reset asserted during beat 2 of a split store.
        @(posedge clk); #1;
        ready_mode = 1;
        memory_address = 32'h307; memory_write_sections = 3'b011; store_value = 32'h1234;
        access_enable = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("midreset in beat2 valid", 32'(bus.bus_valid), 32'h1);
        chk("midreset in beat2 addr", bus.bus_address, 32'h308);
        reset_n = 1'b0; #1;
        chk("midreset bus_valid", 32'(bus.bus_valid), 32'h0);
        chk("midreset bus_write", 32'(bus.bus_write), 32'h0);
        chk("midreset bus_address", bus.bus_address, 32'h0);
        chk("midreset byte_enable", 32'(bus.bus_byte_enable), 32'h0);
        chk("midreset load_value", load_value, 32'h0);
        chk("midreset stall follows enable", 32'(stall), 32'h1);
        access_enable = 1'b0; #1;
        chk("midreset stall low", 32'(stall), 32'h0);
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;
        chk("after reset idle", 32'(bus.bus_valid), 32'h0);
        @(posedge clk); #1;
        chk("after reset still idle", 32'(bus.bus_valid), 32'h0);
        cur_load = 32'h0;

        for (int i = 0; i < 80; i++) begin
            logic [31:0] a, v;
            logic [2:0]  s;
            int          mode;
            string       tag;
            a    = ($urandom_range(0, 4) == 0) ? (32'hFFFFFFFC + 32'($urandom_range(0, 3))) : $urandom;
            s    = secs[$urandom_range(0, 6)];
            v    = $urandom;
            mode = ($urandom_range(0, 3) == 0) ? 1 : 2;
            tag  = $sformatf("rnd%0d", i);
            build_model(a, s, v, cur_load);
            run_access(a, s, v, mode, sn, vn, en, lv);
            check_beats(tag);
            chk({tag, " load_value"}, lv, cur_load);
            chk({tag, " bus_error"}, 32'(en), 32'h0);
            if (mode == 1)
                chk({tag, " stall cycles"}, 32'(sn), 32'(exp_q.size() + 1));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
